// File: rtl/reg_bank_pkg.sv
// Shared types for the reg_bank_mc register bank: operation encoding and its width.
package reg_bank_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD  = 2'd0,
    OP_INC   = 2'd1,
    OP_DEC   = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

endpackage

// File: rtl/reg_bank_mc_if.sv
// Command/read bus of reg_bank_mc; master drives commands and read addresses, slave returns data.
interface reg_bank_mc_if #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
);
  localparam int SEL_W  = $clog2(CHANNELS);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                             CE;
  logic [SEL_W-1:0]                 S;
  logic [CHANNELS*WIDTH-1:0]        I;
  logic [ADDR_W-1:0]                WA;
  logic [reg_bank_pkg::OP_W-1:0]    OP;
  logic [ADDR_W-1:0]                RA0;
  logic [ADDR_W-1:0]                RA1;
  logic [WIDTH-1:0]                 Q0;
  logic [WIDTH-1:0]                 Q1;
  logic [DEPTH-1:0]                 VALID;
  logic [CNT_W-1:0]                 WR_CNT;
  logic                             OVF;

  modport master (
    output CE, S, I, WA, OP, RA0, RA1,
    input  Q0, Q1, VALID, WR_CNT, OVF
  );

  modport slave (
    input  CE, S, I, WA, OP, RA0, RA1,
    output Q0, Q1, VALID, WR_CNT, OVF
  );
endinterface

// File: rtl/reg_bank_alu.sv
// Combinational next-value logic for the addressed register entry.
module reg_bank_alu
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] din,
  input  op_e              op,
  output logic [WIDTH-1:0] next_val,
  output logic             wrap,
  output logic             next_valid
);

  always_comb begin
    next_val   = old_val;
    wrap       = 1'b0;
    next_valid = 1'b1;
    case (op)
      OP_LOAD:  next_val = din;
      OP_INC: begin
        next_val = old_val + 1'b1;
        wrap     = &old_val;
      end
      OP_DEC: begin
        next_val = old_val - 1'b1;
        wrap     = ~|old_val;
      end
      OP_CLEAR: begin
        next_val   = '0;
        next_valid = 1'b0;
      end
      default: next_val = old_val;
    endcase
  end

endmodule

// File: rtl/reg_bank_mc.sv
// Multi-register bank with channel-select load, inc/dec/clear, two read ports, valid flags,
// saturating write counter and sticky wrap flag. Optional macro: REG_BANK_BYPASS_EN.
module reg_bank_mc
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8
) (
  input logic         C,
  input logic         Clr,
  reg_bank_mc_if.slave bus
);

  localparam int SEL_W  = $clog2(CHANNELS);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [SEL_W:0]  S_LIM = (SEL_W + 1)'(CHANNELS);
  localparam logic [ADDR_W:0] A_LIM = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CNT_W-1:0] wr_cnt;
  logic             ovf;

  logic             wa_ok, s_ok, accept;
  logic [WIDTH-1:0] din, old_val, next_val;
  logic             wrap, next_valid;

  assign wa_ok  = {1'b0, bus.WA} < A_LIM;
  assign s_ok   = {1'b0, bus.S} < S_LIM;
  assign accept = bus.CE && !Clr && wa_ok && s_ok;

  always_comb begin
    din = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.S == SEL_W'(k)) din = bus.I[k*WIDTH +: WIDTH];
    end
  end

  assign old_val = wa_ok ? regs[bus.WA] : '0;

  reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
    .old_val   (old_val),
    .din       (din),
    .op        (op_e'(bus.OP)),
    .next_val  (next_val),
    .wrap      (wrap),
    .next_valid(next_valid)
  );

  always_ff @(posedge C) begin
    if (Clr) begin
      for (int unsigned n = 0; n < DEPTH; n++) regs[n] <= '0;
      valid  <= '0;
      wr_cnt <= '0;
      ovf    <= 1'b0;
    end else if (accept) begin
      regs[bus.WA]  <= next_val;
      valid[bus.WA] <= next_valid;
      if (wrap) ovf <= 1'b1;
      if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Bypass shows the in-flight result for a matching read address; Clr blanks both ports.
  always_comb begin
    bus.Q0 = '0;
    bus.Q1 = '0;
    if ({1'b0, bus.RA0} < A_LIM) bus.Q0 = regs[bus.RA0];
    if ({1'b0, bus.RA1} < A_LIM) bus.Q1 = regs[bus.RA1];
`ifdef REG_BANK_BYPASS_EN
    if (accept && bus.WA == bus.RA0) bus.Q0 = next_val;
    if (accept && bus.WA == bus.RA1) bus.Q1 = next_val;
    if (Clr) begin
      bus.Q0 = '0;
      bus.Q1 = '0;
    end
`endif
  end

  assign bus.VALID  = valid;
  assign bus.WR_CNT = wr_cnt;
  assign bus.OVF    = ovf;

endmodule

// File: tb/tb_reg_bank_mc.sv
// Directed-step bench for reg_bank_mc with an expected-state scoreboard queue.
module tb_reg_bank_mc;
  import reg_bank_pkg::*;

  localparam int WIDTH    = 4;
  localparam int DEPTH    = 4;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 8;

  logic C = 1'b0;
  logic Clr;

  reg_bank_mc_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  reg_bank_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
    .C  (C),
    .Clr(Clr),
    .bus(bus)
  );

  always #5 C = ~C;

  typedef struct packed {
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] valid;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_reg [4];
  logic [3:0] m_valid;
  logic [7:0] m_cnt;
  logic       m_ovf;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input string tag, input logic clr, input logic ce, input logic s,
                      input logic [3:0] i0, input logic [3:0] i1, input logic [1:0] wa,
                      input op_e op, input logic [1:0] ra0, input logic [1:0] ra1);
    logic [3:0] nv;
    logic       nval, wrp;
    logic [3:0] pre0, pre1;
    exp_t       e;
    @(negedge C);
    Clr     = clr;
    bus.CE  = ce;
    bus.S   = s;
    bus.I   = {i1, i0};
    bus.WA  = wa;
    bus.OP  = op;
    bus.RA0 = ra0;
    bus.RA1 = ra1;
    nv = m_reg[wa];
    nval = 1'b1;
    wrp = 1'b0;
    case (op)
      OP_LOAD:  nv = s ? i1 : i0;
      OP_INC:   begin wrp = (m_reg[wa] == 4'hF); nv = m_reg[wa] + 4'd1; end
      OP_DEC:   begin wrp = (m_reg[wa] == 4'h0); nv = m_reg[wa] - 4'd1; end
      default:  begin nv = 4'h0; nval = 1'b0; end
    endcase
    pre0 = m_reg[ra0];
    pre1 = m_reg[ra1];
`ifdef REG_BANK_BYPASS_EN
    if (ce && !clr && wa == ra0) pre0 = nv;
    if (ce && !clr && wa == ra1) pre1 = nv;
    if (clr) begin pre0 = 4'h0; pre1 = 4'h0; end
`endif
    #1;
    chk({tag, "_pre_q0"}, 32'(bus.Q0), 32'(pre0));
    chk({tag, "_pre_q1"}, 32'(bus.Q1), 32'(pre1));
    if (clr) begin
      for (int n = 0; n < 4; n++) m_reg[n] = 4'h0;
      m_valid = 4'h0;
      m_cnt   = 8'h0;
      m_ovf   = 1'b0;
    end else if (ce) begin
      m_reg[wa]   = nv;
      m_valid[wa] = nval;
      if (wrp) m_ovf = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    sb.push_back('{q0: m_reg[ra0], q1: m_reg[ra1], valid: m_valid, cnt: m_cnt, ovf: m_ovf});
    @(posedge C);
    #1;
    e = sb.pop_front();
    chk({tag, "_q0"},    32'(bus.Q0),     32'(e.q0));
    chk({tag, "_q1"},    32'(bus.Q1),     32'(e.q1));
    chk({tag, "_valid"}, 32'(bus.VALID),  32'(e.valid));
    chk({tag, "_cnt"},   32'(bus.WR_CNT), 32'(e.cnt));
    chk({tag, "_ovf"},   32'(bus.OVF),    32'(e.ovf));
  endtask

  initial begin
    Clr = 1'b1;
    bus.CE = 1'b0; bus.S = 1'b0; bus.I = '0; bus.WA = '0; bus.OP = OP_LOAD;
    bus.RA0 = '0; bus.RA1 = '0;
    for (int n = 0; n < 4; n++) m_reg[n] = 4'h0;
    m_valid = 4'h0; m_cnt = 8'h0; m_ovf = 1'b0;

    // 1: reset overrides an enabled load
    step("rst_a", 1, 1, 0, 4'b1010, 4'b1011, 2'd0, OP_LOAD, 2'd0, 2'd1);
    step("rst_b", 1, 1, 1, 4'b1010, 4'b1011, 2'd1, OP_LOAD, 2'd0, 2'd1);
    chk("rst_q0", 32'(bus.Q0), 32'h0);
    chk("rst_valid", 32'(bus.VALID), 32'h0);

    // 2: loads from both channels
    step("ld2", 0, 1, 0, 4'b1010, 4'b0000, 2'd2, OP_LOAD, 2'd2, 2'd3);
    step("ld3", 0, 1, 1, 4'b0000, 4'b1011, 2'd3, OP_LOAD, 2'd2, 2'd3);
    chk("t2_q0", 32'(bus.Q0), 32'b1010);
    chk("t2_q1", 32'(bus.Q1), 32'b1011);
    chk("t2_valid", 32'(bus.VALID), 32'b1100);
    chk("t2_cnt", 32'(bus.WR_CNT), 32'd2);

    // 3: CE low holds everything
    for (int k = 0; k < 5; k++)
      step("hold", 0, 0, k[0], 4'b1111, 4'b1110, 2'(k), op_e'(k[1:0]), 2'd2, 2'd3);
    chk("t3_q0", 32'(bus.Q0), 32'b1010);
    chk("t3_q1", 32'(bus.Q1), 32'b1011);
    chk("t3_cnt", 32'(bus.WR_CNT), 32'd2);

    // 4: inc/dec wrap and clear
    step("ld1",  0, 1, 0, 4'b1111, 4'b0000, 2'd1, OP_LOAD,  2'd1, 2'd2);
    step("inc1", 0, 1, 0, 4'b0000, 4'b0000, 2'd1, OP_INC,   2'd1, 2'd1);
    chk("t4_inc_q0", 32'(bus.Q0), 32'h0);
    chk("t4_inc_ovf", 32'(bus.OVF), 32'h1);
    step("dec1", 0, 1, 0, 4'b0000, 4'b0000, 2'd1, OP_DEC,   2'd1, 2'd3);
    chk("t4_dec_q0", 32'(bus.Q0), 32'hF);
    chk("t4_dec_ovf", 32'(bus.OVF), 32'h1);
    step("clr1", 0, 1, 0, 4'b0000, 4'b0000, 2'd1, OP_CLEAR, 2'd1, 2'd2);
    chk("t4_clr_q0", 32'(bus.Q0), 32'h0);
    chk("t4_clr_valid", 32'(bus.VALID), 32'b1100);

    // 5: reset in the same cycle as a load
    step("rstld", 1, 1, 0, 4'b0110, 4'b0000, 2'd0, OP_LOAD, 2'd0, 2'd2);
    chk("t5_q0", 32'(bus.Q0), 32'h0);
    chk("t5_valid", 32'(bus.VALID), 32'h0);
    chk("t5_cnt", 32'(bus.WR_CNT), 32'h0);

    // 6: write to the address being read (pre-edge value depends on build)
    step("pre1", 0, 1, 0, 4'b0111, 4'b0000, 2'd1, OP_LOAD, 2'd1, 2'd0);
    step("byp",  0, 1, 0, 4'b0001, 4'b0000, 2'd1, OP_LOAD, 2'd1, 2'd1);
    chk("t6_q0", 32'(bus.Q0), 32'b0001);

    // counter saturation, with repeated wraps on reg0
    for (int k = 0; k < 258; k++)
      step("sat", 0, 1, 0, 4'b0000, 4'b0000, 2'd0, OP_INC, 2'd0, 2'd1);
    chk("sat_cnt", 32'(bus.WR_CNT), 32'hFF);
    chk("sat_ovf", 32'(bus.OVF), 32'h1);
    chk("sat_q0", 32'(bus.Q0), 32'((258 % 16)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_mc.md
Name: reg_bank_mc

Overview:
Parametrised multi-register bank that succeeds the single 4-bit two-input selectable register. It holds DEPTH registers of WIDTH bits and loads from one of CHANNELS selectable input channels. Each register can also be incremented, decremented or cleared individually. Two combinational read ports serve the sensor/actuator control path, alongside per-entry valid flags, a write counter and a sticky wrap flag.

Parameters:
WIDTH, 4, bits per register
DEPTH, 4, number of registers (>=2)
CHANNELS, 2, number of input channels selectable by S (>=2)
CNT_W, 8, width of the accepted-write counter
(derived localparams: SEL_W = $clog2(CHANNELS), ADDR_W = $clog2(DEPTH))

Ports:
C  in  1  clock; all state updates on rising edge
Clr  in  1  reset, synchronous, active-high
CE  in  1  write/operation enable
S  in  SEL_W  input channel select
I  in  CHANNELS*WIDTH  packed input channels; channel k = I[k*WIDTH +: WIDTH]
WA  in  ADDR_W  target register address
OP  in  2  operation: LOAD=0, INC=1, DEC=2, CLEAR=3
RA0  in  ADDR_W  read address, port 0
RA1  in  ADDR_W  read address, port 1
Q0  out  WIDTH  contents of register RA0
Q1  out  WIDTH  contents of register RA1
VALID  out  DEPTH  bit n set when register n holds loaded/computed data
WR_CNT  out  CNT_W  count of accepted operations, saturating
OVF  out  1  sticky flag: an INC or DEC wrapped

Behaviour:
- One clock C; reset Clr is synchronous, active-high.
- Clr=1 at an edge: all registers 0, VALID=0, WR_CNT=0, OVF=0. Clr overrides CE in the same cycle.
- Accepted operation requires CE=1, Clr=0, WA<DEPTH and S<CHANNELS. Otherwise no register, VALID, WR_CNT or OVF change.
- LOAD: reg[WA] <= channel S; VALID[WA] <= 1.
- INC: reg[WA] <= reg[WA]+1, modulo 2^WIDTH; VALID[WA] <= 1. If the old value was all ones, it wraps to 0 and OVF <= 1.
- DEC: reg[WA] <= reg[WA]-1, modulo 2^WIDTH; VALID[WA] <= 1. If the old value was 0, it wraps to all ones and OVF <= 1.
- CLEAR: reg[WA] <= 0; VALID[WA] <= 0.
- An accepted operation increments WR_CNT. WR_CNT holds at all ones and does not wrap.
- OVF is cleared only by Clr.
- CE=0: all state holds regardless of S, I, WA and OP.
- Reads are combinational. Q0/Q1 reflect register state after the most recent edge, so write-to-read latency is 1 cycle.
- RA0/RA1 >= DEPTH gives Q=0.
- RA0 == RA1 is legal; both ports show the same value.
- Only one register changes per cycle. There is no multi-write conflict.

Optional Feature:
Macro REG_BANK_BYPASS_EN.
- Defined: when an accepted operation targets WA equal to RA0 (or RA1), that port shows the next value combinationally in the same cycle. The next value is the LOAD data, INC/DEC result, or 0 for CLEAR.
- Not defined: ports show the stored value; the new value appears after the edge.
- With the macro defined, Clr=1 forces Q0=Q1=0 combinationally. Without it, Clr takes effect at the edge only.

Decomposition:
- Package reg_bank_pkg: enum typedef op_e (OP_LOAD, OP_INC, OP_DEC, OP_CLEAR) and a 2-bit width constant for OP.
- Sub-module reg_bank_alu (combinational): takes the old value, the channel data and op. It returns the next value, the wrap flag and the next valid bit.
- The top instantiates one reg_bank_alu instance for the addressed entry, plus the storage array, counter and read muxes.

Test Plan:
1. Clr=1 for 2 cycles with CE=1, OP=LOAD, I={1011,1010} -> Q0=Q1=0000, VALID=0000, WR_CNT=0, OVF=0.
2. CE=1, S=0, I0=1010, WA=2, LOAD; then S=1, I1=1011, WA=3, LOAD; RA0=2, RA1=3 -> Q0=1010, Q1=1011, VALID=1100, WR_CNT=2.
3. CE=0 for 5 cycles while I0=1111, I1=1110 and WA/OP toggle -> Q0=1010, Q1=1011, VALID and WR_CNT unchanged.
4. LOAD 1111 into reg1, then INC reg1 -> reg1=0000, OVF=1. DEC reg1 -> 1111, OVF stays 1. CLEAR reg1 -> 0000, VALID[1]=0.
5. Clr=1 in the same cycle as CE=1 LOAD 0110 to WA=0 -> reg0=0000, VALID=0000, WR_CNT=0.
6. RA0=WA=1, LOAD 0001 -> with REG_BANK_BYPASS_EN, Q0=0001 in the same cycle; without it, Q0 keeps the old value until the next edge. Run the bench in both builds.
